// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: IR geometry, capture pattern, opcodes and IR monitor states.
// Both the IR shift stage and the IR shift monitor take their defaults from here.
package jtag_pkg;

    localparam int IR_WIDTH_DEF  = 4;
    localparam int CNT_WIDTH_DEF = 6;

    localparam logic [IR_WIDTH_DEF-1:0] CAPTURE_VAL_DEF = 4'b0101;

    localparam logic [IR_WIDTH_DEF-1:0] OP_EXTEST = 4'b0000;
    localparam logic [IR_WIDTH_DEF-1:0] OP_IDCODE = 4'b0001;
    localparam logic [IR_WIDTH_DEF-1:0] OP_SAMPLE = 4'b0010;
    localparam logic [IR_WIDTH_DEF-1:0] OP_BYPASS = 4'b1111;

    typedef enum logic [2:0] {
        MON_IDLE     = 3'd0,
        MON_CAPTURED = 3'd1,
        MON_SHIFTING = 3'd2,
        MON_EXACT    = 3'd3,
        MON_OVER     = 3'd4,
        MON_ERROR    = 3'd5
    } mon_state_e;

endpackage

// File: rtl/ir_shift_monitor_if.sv
// TAP-side signal bundle of the IR shift monitor: serial input, TAP state strobes and status.
// master drives TDI/CAPTUREIR/SHIFTIR, slave is the monitor.
interface ir_shift_monitor_if
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH  = IR_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
);

    logic                 TDI;
    logic                 CAPTUREIR;
    logic                 SHIFTIR;
    logic [CNT_WIDTH-1:0] SHIFT_COUNT;
    logic [IR_WIDTH-1:0]  IR_SHADOW;
    logic                 LEN_OK;
    logic                 OVERSHIFT;
    logic                 SEQ_ERR;
    logic [2:0]           MON_STATE;
    logic                 PARITY;

    modport master (
        output TDI, CAPTUREIR, SHIFTIR,
        input  SHIFT_COUNT, IR_SHADOW, LEN_OK, OVERSHIFT, SEQ_ERR, MON_STATE, PARITY
    );

    modport slave (
        input  TDI, CAPTUREIR, SHIFTIR,
        output SHIFT_COUNT, IR_SHADOW, LEN_OK, OVERSHIFT, SEQ_ERR, MON_STATE, PARITY
    );

endinterface

// File: rtl/ir_shift_counter.sv
// Saturating shift counter; flags compare the count this edge would produce against IR_WIDTH,
// so the monitor FSM can pick its next state in the same cycle.
module ir_shift_counter
    import jtag_pkg::*;
#(
    parameter int IR_WIDTH  = IR_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 CLOCKIR,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 next_eq,
    output logic                 next_gt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] TARGET  = CNT_WIDTH'(IR_WIDTH);

    logic [CNT_WIDTH-1:0] count_inc;

    always_comb begin
        count_inc = (count == CNT_MAX) ? count : count + CNT_WIDTH'(1);
        next_eq   = (count_inc == TARGET);
        next_gt   = (count_inc >  TARGET);
    end

    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge CLOCKIR or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count_inc;
        end
    end

endmodule

// File: rtl/ir_shift_monitor.sv
// IR shift monitor: tracks shift length and a shadow of the last IR_WIDTH bits after Capture-IR.
// Optional running parity of shifted bits is enabled by defining IR_MON_PARITY_EN.
module ir_shift_monitor
    import jtag_pkg::*;
#(
    parameter int                  IR_WIDTH    = IR_WIDTH_DEF,
    parameter int                  CNT_WIDTH   = CNT_WIDTH_DEF,
    parameter logic [IR_WIDTH-1:0] CAPTURE_VAL = CAPTURE_VAL_DEF
) (
    input  logic              CLOCKIR,
    input  logic              rst,
    ir_shift_monitor_if.slave bus
);

    mon_state_e           state;
    mon_state_e           state_nxt;
    logic [IR_WIDTH-1:0]  shadow;
    logic [CNT_WIDTH-1:0] count;
    logic                 capture;
    logic                 shift_ok;
    logic                 next_eq;
    logic                 next_gt;
    logic                 parity;

    // A shift is only counted once a capture has established a known starting point.
    assign capture  = bus.CAPTUREIR;
    assign shift_ok = !bus.CAPTUREIR && bus.SHIFTIR &&
                      (state != MON_IDLE) && (state != MON_ERROR);

    ir_shift_counter #(
        .IR_WIDTH  (IR_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_counter (
        .CLOCKIR (CLOCKIR),
        .rst     (rst),
        .clear   (capture),
        .inc     (shift_ok),
        .count   (count),
        .next_eq (next_eq),
        .next_gt (next_gt)
    );

    always_ff @(posedge CLOCKIR or posedge rst) begin
        if (rst) begin
            state <= MON_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: default assignment first so no path through the block leaves state_nxt unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (bus.CAPTUREIR) begin
            state_nxt = MON_CAPTURED;
        end else if (bus.SHIFTIR) begin
            if (!shift_ok)    state_nxt = MON_ERROR;
            else if (next_gt) state_nxt = MON_OVER;
            else if (next_eq) state_nxt = MON_EXACT;
            else              state_nxt = MON_SHIFTING;
        end
    end

    // NOTE: the shadow is a plain register, so it takes an async reset like every other flop.
    always_ff @(posedge CLOCKIR or posedge rst) begin
        if (rst) begin
            shadow <= '0;
        end else if (capture) begin
            shadow <= CAPTURE_VAL;
        end else if (shift_ok) begin
            shadow <= {bus.TDI, shadow[IR_WIDTH-1:1]};
        end
    end

`ifdef IR_MON_PARITY_EN
    always_ff @(posedge CLOCKIR or posedge rst) begin
        if (rst) begin
            parity <= 1'b0;
        end else if (capture) begin
            parity <= 1'b0;
        end else if (shift_ok) begin
            parity <= parity ^ bus.TDI;
        end
    end
`else
    assign parity = 1'b0;
`endif

    // Flags decode the registered state only, keeping them quasi-static between edges.
    always_comb begin
        bus.SHIFT_COUNT = count;
        bus.IR_SHADOW   = shadow;
        bus.LEN_OK      = (state == MON_EXACT);
        bus.OVERSHIFT   = (state == MON_OVER);
        bus.SEQ_ERR     = (state == MON_ERROR);
        bus.MON_STATE   = state;
        bus.PARITY      = parity;
    end

endmodule

// File: tb/tb_ir_shift_monitor.sv
// Bench for ir_shift_monitor: directed literal checks plus randomized traffic compared each
// cycle against a count/shadow model; honours IR_MON_PARITY_EN like the design.
module tb_ir_shift_monitor;
    import jtag_pkg::*;

    localparam int IRW = 4;
    localparam int CW  = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef IR_MON_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic tck    = 1'b1;
    logic rst    = 1'b1;
    logic glitch = 1'b0;
    logic CLOCKIR;
    int   checks = 0;
    int   errors = 0;
    bit   cmp_en = 1'b0;

    ir_shift_monitor_if #(.IR_WIDTH(IRW), .CNT_WIDTH(CW)) bus ();

    // Gated IR clock: held high unless a capture/shift (or forced glitch edge) is requested.
    assign CLOCKIR = tck | ~(bus.CAPTUREIR | bus.SHIFTIR | glitch);

    ir_shift_monitor #(
        .IR_WIDTH    (IRW),
        .CNT_WIDTH   (CW),
        .CAPTURE_VAL (CAPTURE_VAL_DEF)
    ) dut (
        .CLOCKIR (CLOCKIR),
        .rst     (rst),
        .bus     (bus)
    );

    always #5 tck = ~tck;

    // Behavioural model: has a capture happened, error flag, bit count, shadow, parity.
    bit         m_valid, m_err, m_par;
    int         m_cnt;
    logic [3:0] m_shadow;

    always @(posedge tck or posedge rst) begin
        if (rst) begin
            m_valid <= 0; m_err <= 0; m_par <= 0; m_cnt <= 0; m_shadow <= '0;
        end else if (bus.CAPTUREIR) begin
            m_valid <= 1; m_err <= 0; m_par <= 0; m_cnt <= 0; m_shadow <= CAPTURE_VAL_DEF;
        end else if (bus.SHIFTIR) begin
            if (!m_valid || m_err) begin
                m_err <= 1;
            end else begin
                m_shadow <= (m_shadow >> 1) | (4'(bus.TDI) << (IRW - 1));
                m_cnt    <= (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
                m_par    <= m_par ^ bus.TDI;
            end
        end
    end

    function automatic int exp_state();
        if (m_err)             return 5;
        else if (!m_valid)     return 0;
        else if (m_cnt == 0)   return 1;
        else if (m_cnt < IRW)  return 2;
        else if (m_cnt == IRW) return 3;
        else                   return 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge tck) begin
        if (cmp_en) begin
            check("model_count",  32'(bus.SHIFT_COUNT), 32'(m_cnt));
            check("model_shadow", 32'(bus.IR_SHADOW),   32'(m_shadow));
            check("model_len_ok", 32'(bus.LEN_OK),      32'(!m_err && m_valid && m_cnt == IRW));
            check("model_over",   32'(bus.OVERSHIFT),   32'(!m_err && m_valid && m_cnt > IRW));
            check("model_seqerr", 32'(bus.SEQ_ERR),     32'(m_err));
            check("model_state",  32'(bus.MON_STATE),   32'(exp_state()));
            check("model_parity", 32'(bus.PARITY),      32'(PAR_EN & m_par));
        end
    end

    task automatic op(input bit c, input bit s, input bit d, input bit g);
        @(posedge tck);
        #1;
        bus.CAPTUREIR = c;
        bus.SHIFTIR   = s;
        bus.TDI       = d;
        glitch        = g;
    endtask

    task automatic settle();
        op(0, 0, 0, 0);
        @(negedge tck);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_count"},  32'(bus.SHIFT_COUNT), 0);
        check({tag, "_shadow"}, 32'(bus.IR_SHADOW),   0);
        check({tag, "_len_ok"}, 32'(bus.LEN_OK),      0);
        check({tag, "_over"},   32'(bus.OVERSHIFT),   0);
        check({tag, "_seqerr"}, 32'(bus.SEQ_ERR),     0);
        check({tag, "_state"},  32'(bus.MON_STATE),   0);
        check({tag, "_parity"}, 32'(bus.PARITY),      0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.TDI = 0; bus.CAPTUREIR = 0; bus.SHIFTIR = 0;
        #2;
        check_all_zero("reset");
        @(posedge tck);
        #1 rst = 0;
        cmp_en = 1;

        op(1, 0, 0, 0); settle();
        check("cap_state",  32'(bus.MON_STATE),   1);
        check("cap_shadow", 32'(bus.IR_SHADOW),   32'h5);
        check("cap_count",  32'(bus.SHIFT_COUNT), 0);
        check("cap_len_ok", 32'(bus.LEN_OK),      0);

        op(0, 1, 1, 0); op(0, 1, 1, 0); op(0, 1, 1, 0); op(0, 1, 0, 0); settle();
        check("exact_shadow", 32'(bus.IR_SHADOW),   32'h7);
        check("exact_count",  32'(bus.SHIFT_COUNT), 4);
        check("exact_len_ok", 32'(bus.LEN_OK),      1);
        check("exact_over",   32'(bus.OVERSHIFT),   0);
        check("exact_state",  32'(bus.MON_STATE),   3);
        check("exact_parity", 32'(bus.PARITY),      32'(PAR_EN));

        op(1, 0, 0, 0);
        repeat (5) op(0, 1, 1'($urandom), 0);
        settle();
        check("over_count",  32'(bus.SHIFT_COUNT), 5);
        check("over_len_ok", 32'(bus.LEN_OK),      0);
        check("over_flag",   32'(bus.OVERSHIFT),   1);
        check("over_state",  32'(bus.MON_STATE),   4);
        op(1, 0, 0, 0); settle();
        check("recap_over",  32'(bus.OVERSHIFT),   0);
        check("recap_len",   32'(bus.LEN_OK),      0);

        rst = 1; #2 rst = 0;
        op(0, 1, 1, 0); settle();
        check("seq_err",    32'(bus.SEQ_ERR),   1);
        check("seq_state",  32'(bus.MON_STATE), 5);
        check("seq_shadow", 32'(bus.IR_SHADOW), 0);
        op(1, 0, 0, 0); settle();
        check("seq_clear",  32'(bus.SEQ_ERR),   0);
        check("seq_cap",    32'(bus.MON_STATE), 1);

        op(1, 1, 1, 0); settle();
        check("both_count", 32'(bus.SHIFT_COUNT), 0);
        check("both_state", 32'(bus.MON_STATE),   1);
        repeat (70) op(0, 1, 1'($urandom), 0);
        settle();
        check("sat_count", 32'(bus.SHIFT_COUNT), 63);
        check("sat_state", 32'(bus.MON_STATE),   4);

        op(1, 0, 0, 0); op(0, 1, 1, 0); op(0, 1, 1, 0); settle();
        check("mid_count", 32'(bus.SHIFT_COUNT), 2);
        rst = 1;
        #1;
        check_all_zero("async_rst");
        #1 rst = 0;

        repeat (600) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 10)      op(1, 1'($urandom), 1'($urandom), 0);
            else if (r < 70) op(0, 1, 1'($urandom), 0);
            else if (r < 80) op(0, 0, 1'($urandom), 1);
            else             op(0, 0, 1'($urandom), 0);
            if ($urandom_range(0, 99) < 2) begin
                #1 rst = 1;
                #1 rst = 0;
            end
        end
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
